// File: rtl/spi_adc_pkg.sv
// Shared constants and state encoding for the emulated 8-bit serial ADC.
// The default frame geometry matches the real converter read by spi_sensor.
package spi_adc_pkg;

    // Default converter geometry, shared with spi_sensor
    localparam int DATA_W_DEF     = 8;
    localparam int LEAD_ZEROS_DEF = 3;
    localparam int FRAME_BITS_DEF = 16;

    // Frame-format constants
    localparam int   FRAME_CNT_W   = 16;
    localparam logic SCLK_IDLE_LVL = 1'b0;
    localparam logic CS_IDLE_LVL   = 1'b1;

    // Responder FSM encoding, kept as plain constants for legacy tools
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_SHIFT = 2'd1;
    localparam fsm_state_t ST_TAIL  = 2'd2;

endpackage

// File: rtl/spi_adc_responder_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a history flop.
// Rise/fall pulses are derived only from the synchronized level.
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // Resynchronize the pin and keep last cycle's synchronized level for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            hist_q <= RESET_VAL;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~hist_q;
    assign fall_o = ~sync_q & hist_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder that emulates the serial ADC: on a chip-select fall it
// loads a frame of leading zeros, the held sample MSB first, then zeros,
// and shifts one bit per falling sclk so the master can read on the rises.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sclk_i,
    input  logic                   cs_i,
    output logic                   miso_o,
    output logic                   miso_oe_o,
    input  logic [DATA_W-1:0]      sample_i,
    input  logic                   sample_valid_i,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    // Zero bits that follow the data LSB inside one nominal frame
    localparam int PAD_BITS = FRAME_BITS - LEAD_ZEROS - DATA_W;
    localparam int BITCNT_W = $clog2(FRAME_BITS + 1);

    logic sclkFall;
    logic unusedSclkRise;
    logic csFall;
    logic csRise;

    logic [DATA_W-1:0]      hold_q;
    fsm_state_t             state_q,    state_d;
    logic [FRAME_BITS-1:0]  shreg_q,    shreg_d;
    logic [BITCNT_W-1:0]    bitCnt_q,   bitCnt_d;
    logic                   miso_q,     miso_d;
    logic                   misoOe_q,   misoOe_d;
    logic                   busy_q,     busy_d;
    logic                   frameDone_q, frameDone_d;
    logic [FRAME_CNT_W-1:0] frameCnt_q, frameCnt_d;

    logic [FRAME_BITS-1:0]  loadWord;
    logic [BITCNT_W-1:0]    bitCntInc;

    // The master samples on sclk rises, so only the sclk fall pulse drives the responder
    spi_pin_sync #(.RESET_VAL(SCLK_IDLE_LVL)) u_sclkSync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (sclk_i),
        .rise_o (unusedSclkRise),
        .fall_o (sclkFall)
    );

    spi_pin_sync #(.RESET_VAL(CS_IDLE_LVL)) u_csSync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (cs_i),
        .rise_o (csRise),
        .fall_o (csFall)
    );

    assign loadWord  = FRAME_BITS'(hold_q) << PAD_BITS;
    assign bitCntInc = bitCnt_q + BITCNT_W'(1);

    // Hold register captures the next conversion value whenever offered, in any state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else if (sample_valid_i) begin
            hold_q <= sample_i;
        end
    end

    // Frame sequencing: cs rise always wins and returns to idle with the pad released
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitCnt_d    = bitCnt_q;
        miso_d      = miso_q;
        misoOe_d    = misoOe_q;
        busy_d      = busy_q;
        frameDone_d = 1'b0;
        frameCnt_d  = frameCnt_q;

        if (csRise) begin
            state_d  = ST_IDLE;
            shreg_d  = '0;
            miso_d   = 1'b0;
            misoOe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csFall) begin
                        state_d  = ST_SHIFT;
                        shreg_d  = loadWord;
                        bitCnt_d = '0;
                        miso_d   = loadWord[FRAME_BITS-1];
                        misoOe_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sclkFall) begin
                        shreg_d  = shreg_q << 1;
                        bitCnt_d = bitCntInc;
                        miso_d   = shreg_q[FRAME_BITS-2];
                        if (bitCntInc == BITCNT_W'(FRAME_BITS)) begin
                            state_d     = ST_TAIL;
                            frameDone_d = 1'b1;
                            frameCnt_d  = frameCnt_q + 1'b1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (sclkFall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered frame state and outputs, so miso changes one clk after the detected edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bitCnt_q    <= '0;
            miso_q      <= 1'b0;
            misoOe_q    <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            frameCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitCnt_q    <= bitCnt_d;
            miso_q      <= miso_d;
            misoOe_q    <= misoOe_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
            frameCnt_q  <= frameCnt_d;
        end
    end

    assign miso_o       = miso_q;
    assign miso_oe_o    = misoOe_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frameDone_q;
    assign frame_cnt_o  = frameCnt_q;

endmodule
